rsa_mont_mult: RTL
==================

# rsa_mont_mult

Bit-serial radix-2 Montgomery modular multiplier, computing `result = A·B·R⁻¹ mod N` with `R = 2^WIDTH`. It is the arithmetic stage directly downstream of the register/control path. `rsa_unit` issues one multiply per square or multiply step of the exponentiation loop, driving operands, `start` and `en` from its sequencer and consuming `result` on `done`. One multiply occupies the block for WIDTH+2 enabled cycles.

## Interface
Parameters:
- `WIDTH`, default 8: operand, modulus and result width in bits; legal range 4..32.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rstb`  in  1  reset, asynchronous and active-low.
- `en`  in  1  clock enable; when low, all state and outputs hold.
- `start`  in  1  single-cycle request; sampled only in IDLE or DONE with `en`=1.
- `a`  in  WIDTH  multiplicand; requires `a < n`.
- `b`  in  WIDTH  multiplier; requires `b < n`.
- `n`  in  WIDTH  modulus; must be odd.
- `busy`  out  1  high in CALC and CORR.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  WIDTH  product, held until the next accepted start.
- `err`  out  1  operand-check flag (see Configuration).

## Operation
- Reset values:
  - State IDLE.
  - `busy`, `done`, `err` = 0.
  - `result` = 0.
  - Accumulator `S` and bit counter = 0.
- On an accepted start, `a`, `b` and `n` are latched into internal registers, so the operand inputs may change afterwards. `S` clears to 0, the counter clears to 0, and the FSM enters CALC.
- CALC runs one iteration per enabled edge on bit `i` = counter of latched A:
  - `S1 = S + (A[i] ? B : 0)`.
  - `S2 = S1 + (S1[0] ? N : 0)`.
  - `S = S2 >> 1`.
  - After WIDTH iterations the FSM goes to CORR.
- `S` is WIDTH+2 bits wide. The invariant `S < 2N` must hold with no overflow.
- CORR: `result = (S >= N) ? S − N : S`, truncated to WIDTH bits. The FSM then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE. A start sampled in DONE is accepted and the FSM goes directly to CALC (back-to-back operation).
- A start while busy is ignored. It is neither queued nor flagged.
- `en` low in any state freezes state, counter, `S` and all outputs. `done` remains high if frozen in DONE and is emitted exactly once on resume.
- `rstb` low mid-operation aborts immediately to the reset values. No `done` is produced for the aborted multiply.
- Without the checker, `n` even or operands ≥ `n` gives an undefined result, but the FSM timing is unchanged.

## Timing
- The start is sampled on edge t, and edges are counted only while `en`=1.
- `busy` rises after edge t and falls after edge t+WIDTH+1.
- `done` and `result` are registered and valid in the cycle after edge t+WIDTH+1. Total latency from start to done is WIDTH+2 edges.
- Back-to-back throughput is one result per WIDTH+2 cycles.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- Macro `RSA_MONT_OPERAND_CHECK_EN`.
- Defined:
  - The operands are checked at start (`n[0]==0`, `a>=n` or `b>=n`).
  - On failure the FSM skips CALC and CORR and enters DONE on the edge after start, with `result`=0 and `err`=1.
  - `err` is cleared by the next accepted start with legal operands and by reset.
- Undefined: `err` is tied to 0, no comparators are synthesized, and every start follows the full WIDTH+2 path.

## Test plan
1. WIDTH=8, a=5, b=7, n=13, one start pulse -> `done` exactly 10 cycles later, `result`=1, `busy` high for 9 cycles.
2. WIDTH=8, a=200, b=250, n=251 -> `result`=211. Also a=1, b=1, n=13 -> 3. Also a=0, b=99, n=251 -> 0.
3. Start issued in the DONE cycle of test 1 with a=1, b=1, n=13 -> second `done` 10 cycles later, `result`=3. A start pulse mid-CALC is ignored, with no extra `done`.
4. `en` low for 5 cycles during CALC of test 1 -> `done` arrives 15 cycles after start, `result`=1, outputs stable while stalled.
5. `rstb` asserted at CALC iteration 4, then a new multiply a=5, b=7, n=13 -> outputs reset to 0 immediately, no `done` for the aborted op, and the new op returns 1.
6. With `RSA_MONT_OPERAND_CHECK_EN`, n=12 -> `done` one cycle after start, `err`=1, `result`=0. The next legal op clears `err`. Without the macro, `err` stays 0 throughout.

Source files
------------

// File: rtl/rsa_mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// Define RSA_MONT_OPERAND_CHECK_EN to add the operand legality check and err flag.
module rsa_mont_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = WIDTH + 2;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StCorr,
    StDone
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [SW-1:0]    s_q;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    s1;
  logic [SW-1:0]    s2;
  logic [SW-1:0]    s_sub;
  logic             s_ge_n;
  logic             bad_ops;

  always_comb begin
    s1     = s_q + (a_sh[0] ? {2'b00, b_q} : '0);
    s2     = s1 + (s1[0] ? {2'b00, n_q} : '0);
    s_ge_n = (s_q >= {2'b00, n_q});
    s_sub  = s_q - {2'b00, n_q};
  end

`ifdef RSA_MONT_OPERAND_CHECK_EN
  assign bad_ops = ~n[0] | (a >= n) | (b >= n);
`else
  assign bad_ops = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= StIdle;
      a_sh   <= '0;
      b_q    <= '0;
      n_q    <= '0;
      s_q    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef RSA_MONT_OPERAND_CHECK_EN
      err    <= 1'b0;
`endif
    end else if (en) begin
      done <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          state <= StIdle;
          if (start) begin
            a_sh <= a;
            b_q  <= b;
            n_q  <= n;
            s_q  <= '0;
            cnt  <= '0;
            if (bad_ops) begin
              // Illegal operands bypass the datapath entirely.
              state  <= StDone;
              done   <= 1'b1;
              busy   <= 1'b0;
              result <= '0;
`ifdef RSA_MONT_OPERAND_CHECK_EN
              err    <= 1'b1;
`endif
            end else begin
              state <= StCalc;
              busy  <= 1'b1;
`ifdef RSA_MONT_OPERAND_CHECK_EN
              err   <= 1'b0;
`endif
            end
          end
        end
        StCalc: begin
          s_q  <= s2 >> 1;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= StCorr;
          end
        end
        StCorr: begin
          result <= s_ge_n ? s_sub[WIDTH-1:0] : s_q[WIDTH-1:0];
          state  <= StDone;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
